// File: rtl/map_collision_probe_if.sv
// Request, ROM tile-port and result signals of the map collision probe.
// The slave view belongs to the probe, the master view to its environment.
interface map_collision_probe_if;
    logic        req_valid;
    logic        req_ready;
    logic [10:0] req_x;
    logic [10:0] req_y;
    logic [15:0] map_addr;
    logic [3:0]  map_data;
    logic        rsp_valid;
    logic        rsp_blocked;
    logic [4:0]  rsp_hit_mask;
    logic [3:0]  rsp_tile;

    modport slave (
        input  req_valid, req_x, req_y, map_data,
        output req_ready, map_addr, rsp_valid, rsp_blocked, rsp_hit_mask, rsp_tile
    );

    modport master (
        output req_valid, req_x, req_y, map_data,
        input  req_ready, map_addr, rsp_valid, rsp_blocked, rsp_hit_mask, rsp_tile
    );
endinterface

// File: rtl/map_collision_probe.sv
// Probes the bounding-box corners of a candidate object position against the map ROM
// and reports whether it is blocked. Define PROBE_CENTER_EN to add a fifth, centre probe.
module map_collision_probe #(
    parameter int         OBJ_W     = 32,
    parameter int         OBJ_H     = 32,
    parameter int         SCALE_SH  = 2,
    parameter int         MAP_W     = 256,
    parameter int         MAP_H     = 192,
    parameter logic [3:0] SOLID_MIN = 4'h1,
    parameter int         ROM_LAT   = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    map_collision_probe_if.slave bus
);

`ifdef PROBE_CENTER_EN
    localparam int NPROBE = 5;
`else
    localparam int NPROBE = 4;
`endif

    // ROM_LAT must be at least 1: the drain phase and tag pipeline assume a registered ROM.
    localparam int              LAT_W      = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;
    localparam logic [2:0]      LAST_IDX   = 3'(NPROBE - 1);
    localparam logic [LAT_W-1:0] DRAIN_LAST = LAT_W'(ROM_LAT - 1);
    localparam logic [11:0]     OFF_RX     = 12'(OBJ_W - 1);
    localparam logic [11:0]     OFF_BY     = 12'(OBJ_H - 1);
    localparam logic [11:0]     MAP_W12    = 12'(MAP_W);
    localparam logic [11:0]     MAP_H12    = 12'(MAP_H);
`ifdef PROBE_CENTER_EN
    localparam logic [11:0]     OFF_CX     = 12'(OBJ_W / 2);
    localparam logic [11:0]     OFF_CY     = 12'(OBJ_H / 2);
`endif

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t                     state;
    state_t                     state_next;
    logic [10:0]                x_lat;
    logic [10:0]                y_lat;
    logic [2:0]                 issue_idx;
    logic [15:0]                addr_q;
    logic                       oob_q;
    logic [LAT_W-1:0]           drain_cnt;
    logic [ROM_LAT-1:0]         tag_valid;
    logic [ROM_LAT-1:0]         tag_oob;
    logic [ROM_LAT-1:0][2:0]    tag_idx;
    logic [4:0]                 mask_acc;
    logic [3:0]                 tile_acc;
    logic [4:0]                 rsp_mask_q;
    logic [3:0]                 rsp_tile_q;

    logic [2:0]                 sel_idx;
    logic [11:0]                sel_x;
    logic [11:0]                sel_y;
    logic [11:0]                pt_x;
    logic [11:0]                pt_y;
    logic [11:0]                cell_x;
    logic [11:0]                cell_y;
    logic                       pt_oob;
    logic [15:0]                pt_addr;

    logic                       samp_valid;
    logic                       samp_oob;
    logic [2:0]                 samp_idx;
    logic [3:0]                 samp_code;
    logic                       samp_hit;
    logic [4:0]                 mask_next;
    logic [3:0]                 tile_next;

    // Address of the probe that goes on the bus next: probe 0 from the live request
    // while idle, otherwise the successor of the probe currently issued.
    always_comb begin
        sel_idx = 3'd0;
        sel_x   = {1'b0, bus.req_x};
        sel_y   = {1'b0, bus.req_y};
        if (state != IDLE) begin
            sel_idx = issue_idx + 3'd1;
            sel_x   = {1'b0, x_lat};
            sel_y   = {1'b0, y_lat};
        end
        pt_x = sel_x;
        pt_y = sel_y;
        case (sel_idx)
            3'd1: pt_x = sel_x + OFF_RX;
            3'd2: pt_y = sel_y + OFF_BY;
            3'd3: begin
                pt_x = sel_x + OFF_RX;
                pt_y = sel_y + OFF_BY;
            end
`ifdef PROBE_CENTER_EN
            3'd4: begin
                pt_x = sel_x + OFF_CX;
                pt_y = sel_y + OFF_CY;
            end
`endif
            default: ;
        endcase
        cell_x  = pt_x >> SCALE_SH;
        cell_y  = pt_y >> SCALE_SH;
        pt_oob  = (cell_x >= MAP_W12) || (cell_y >= MAP_H12);
        pt_addr = pt_oob ? 16'h0000 : {cell_y[7:0], cell_x[7:0]};
    end

    // Classify the ROM word returning now; probes arrive in index order, so the first
    // blocked one seen supplies the reported tile code.
    always_comb begin
        samp_valid = tag_valid[ROM_LAT-1];
        samp_oob   = tag_oob[ROM_LAT-1];
        samp_idx   = tag_idx[ROM_LAT-1];
        samp_code  = samp_oob ? 4'hF : bus.map_data;
        samp_hit   = samp_valid && (samp_oob || (samp_code >= SOLID_MIN));
        mask_next  = mask_acc;
        tile_next  = tile_acc;
        if (samp_hit) begin
            if (mask_acc == 5'd0) begin
                tile_next = samp_code;
            end
            mask_next = mask_acc | (5'd1 << samp_idx);
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.req_valid) state_next = ISSUE;
            ISSUE:   if (issue_idx == LAST_IDX) state_next = DRAIN;
            DRAIN:   if (drain_cnt == DRAIN_LAST) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            x_lat      <= '0;
            y_lat      <= '0;
            issue_idx  <= '0;
            addr_q     <= '0;
            oob_q      <= 1'b0;
            drain_cnt  <= '0;
            tag_valid  <= '0;
            tag_oob    <= '0;
            tag_idx    <= '0;
            mask_acc   <= '0;
            tile_acc   <= '0;
            rsp_mask_q <= '0;
            rsp_tile_q <= '0;
        end else begin
            state     <= state_next;
            mask_acc  <= mask_next;
            tile_acc  <= tile_next;

            tag_valid[0] <= (state == ISSUE);
            tag_oob[0]   <= oob_q;
            tag_idx[0]   <= issue_idx;
            for (int i = 1; i < ROM_LAT; i++) begin
                tag_valid[i] <= tag_valid[i-1];
                tag_oob[i]   <= tag_oob[i-1];
                tag_idx[i]   <= tag_idx[i-1];
            end

            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        x_lat     <= bus.req_x;
                        y_lat     <= bus.req_y;
                        addr_q    <= pt_addr;
                        oob_q     <= pt_oob;
                        issue_idx <= 3'd0;
                        drain_cnt <= '0;
                        mask_acc  <= '0;
                        tile_acc  <= '0;
                    end
                end
                ISSUE: begin
                    if (issue_idx != LAST_IDX) begin
                        addr_q    <= pt_addr;
                        oob_q     <= pt_oob;
                        issue_idx <= issue_idx + 3'd1;
                    end
                end
                DRAIN: drain_cnt <= drain_cnt + 1'b1;
                default: ;
            endcase

            if ((state == DRAIN) && (state_next == DONE)) begin
                rsp_mask_q <= mask_next;
                rsp_tile_q <= tile_next;
            end
        end
    end

    assign bus.req_ready = (state == IDLE);
    assign bus.map_addr  = addr_q;
    assign bus.rsp_valid = (state == DONE);
    assign bus.rsp_tile  = rsp_tile_q;
`ifdef PROBE_CENTER_EN
    assign bus.rsp_hit_mask = rsp_mask_q;
`else
    assign bus.rsp_hit_mask = {1'b0, rsp_mask_q[3:0]};
`endif
    assign bus.rsp_blocked = |bus.rsp_hit_mask;

endmodule

// File: tb/tb_map_collision_probe.sv
// Scoreboard bench for map_collision_probe: a registered ROM model feeds tile codes,
// expected results are queued at request time and compared when rsp_valid appears.
module tb_map_collision_probe;
    localparam int         OBJ_W     = 32;
    localparam int         OBJ_H     = 32;
    localparam int         SCALE_SH  = 2;
    localparam int         MAP_W     = 256;
    localparam int         MAP_H     = 192;
    localparam logic [3:0] SOLID_MIN = 4'h1;
    localparam int         ROM_LAT   = 1;
`ifdef PROBE_CENTER_EN
    localparam int NPROBE = 5;
`else
    localparam int NPROBE = 4;
`endif
    localparam int RSP_CYC = NPROBE + ROM_LAT + 1;
    localparam int SPACING = NPROBE + ROM_LAT + 2;

    typedef struct packed {
        logic [4:0] mask;
        logic [3:0] tile;
    } res_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    map_collision_probe_if bus();

    map_collision_probe #(
        .OBJ_W(OBJ_W), .OBJ_H(OBJ_H), .SCALE_SH(SCALE_SH), .MAP_W(MAP_W),
        .MAP_H(MAP_H), .SOLID_MIN(SOLID_MIN), .ROM_LAT(ROM_LAT)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    int   tests_run    = 0;
    int   tests_failed = 0;
    int   rom_mode     = 0;
    res_t exp_q[$];

    logic [15:0] seen_addr [0:15];
    logic        seen_ready[0:15];
    int          rsp_count;
    int          rsp_cyc;
    res_t        seen_res;
    res_t        exp_res;
    logic        seen_blocked;
    logic        accept_ready;

    // Tile contents selected per scenario.
    function automatic logic [3:0] rom_code(input logic [15:0] addr);
        int s;
        case (rom_mode)
            1: return (addr == 16'h1111) ? 4'h3 : 4'h0;
            2: return (addr == 16'h0E0E) ? 4'h5 : 4'h0;
            3: begin
                s = int'(addr[7:0]) + int'(addr[15:8]);
                return ((s % 3) == 0) ? (addr[3:0] | 4'h1) : 4'h0;
            end
            default: return 4'h0;
        endcase
    endfunction

    always @(posedge clk) bus.map_data <= rom_code(bus.map_addr);

    // {oob, address} of probe k for a request at (x, y), in plain integer arithmetic.
    function automatic logic [16:0] probe_info(input int k, input logic [10:0] x, input logic [10:0] y);
        int px, py, cx, cy;
        px = int'(x);
        py = int'(y);
        if (k == 1 || k == 3) px = int'(x) + OBJ_W - 1;
        if (k == 2 || k == 3) py = int'(y) + OBJ_H - 1;
        if (k == 4) begin
            px = int'(x) + OBJ_W / 2;
            py = int'(y) + OBJ_H / 2;
        end
        cx = px >> SCALE_SH;
        cy = py >> SCALE_SH;
        if (cx >= MAP_W || cy >= MAP_H) return {1'b1, 16'h0000};
        return {1'b0, 8'(cy), 8'(cx)};
    endfunction

    function automatic res_t model(input logic [10:0] x, input logic [10:0] y);
        res_t        r;
        logic [16:0] pi;
        logic [3:0]  code;
        r = '0;
        for (int k = 0; k < NPROBE; k++) begin
            pi   = probe_info(k, x, y);
            code = pi[16] ? 4'hF : rom_code(pi[15:0]);
            if (pi[16] || code >= SOLID_MIN) begin
                if (r.mask == 5'd0) r.tile = code;
                r.mask[k] = 1'b1;
            end
        end
        return r;
    endfunction

    // Issue one request and record 12 cycles of DUT behaviour.
    task automatic run_one(input logic [10:0] x, input logic [10:0] y);
        exp_q.delete();
        exp_q.push_back(model(x, y));
        rsp_count = 0;
        rsp_cyc   = -1;
        seen_res  = '0;
        exp_res   = '1;
        @(negedge clk);
        accept_ready  = bus.req_ready;
        bus.req_x     = x;
        bus.req_y     = y;
        bus.req_valid = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            bus.req_valid = 1'b0;
            seen_addr[c]  = bus.map_addr;
            seen_ready[c] = bus.req_ready;
            if (bus.rsp_valid) begin
                rsp_count++;
                rsp_cyc      = c;
                seen_res     = {bus.rsp_hit_mask, bus.rsp_tile};
                seen_blocked = bus.rsp_blocked;
                if (exp_q.size() > 0) exp_res = exp_q.pop_front();
            end
        end
    endtask

    task automatic test_reset();
        bus.req_valid = 1'b0;
        bus.req_x     = '0;
        bus.req_y     = '0;
        rst_n         = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0 || bus.map_addr !== 16'h0000) begin
            tests_failed++;
            $display("[TB] FAIL reset_ctrl: ready=%b valid=%b addr=%h, want 1 0 0000",
                     bus.req_ready, bus.rsp_valid, bus.map_addr);
        end
        tests_run++;
        if (bus.rsp_blocked !== 1'b0 || bus.rsp_hit_mask !== 5'd0 || bus.rsp_tile !== 4'd0) begin
            tests_failed++;
            $display("[TB] FAIL reset_rsp: blocked=%b mask=%b tile=%h, want 0 00000 0",
                     bus.rsp_blocked, bus.rsp_hit_mask, bus.rsp_tile);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        tests_run++;
        if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_release: ready=%b valid=%b, want 1 0", bus.req_ready, bus.rsp_valid);
        end
    endtask

    task automatic test_empty();
        logic [15:0] exp_addr [4];
        exp_addr = '{16'h0A0A, 16'h0A11, 16'h110A, 16'h1111};
        rom_mode = 0;
        run_one(11'd40, 11'd40);
        tests_run++;
        if (accept_ready !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL empty_accept: ready=%b want 1", accept_ready);
        end
        for (int k = 0; k < 4; k++) begin
            tests_run++;
            if (seen_addr[k+1] !== exp_addr[k]) begin
                tests_failed++;
                $display("[TB] FAIL empty_addr%0d: got %h want %h", k, seen_addr[k+1], exp_addr[k]);
            end
        end
        tests_run++;
        if (rsp_count !== 1 || rsp_cyc !== RSP_CYC) begin
            tests_failed++;
            $display("[TB] FAIL empty_rsp_timing: count=%0d cycle=%0d want 1 at %0d", rsp_count, rsp_cyc, RSP_CYC);
        end
        tests_run++;
        if (seen_res !== exp_res || seen_res !== 9'd0 || seen_blocked !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL empty_result: got mask=%b tile=%h blk=%b want %b %h 0",
                     seen_res.mask, seen_res.tile, seen_blocked, exp_res.mask, exp_res.tile);
        end
        for (int c = 1; c <= RSP_CYC + 1; c++) begin
            tests_run++;
            if (seen_ready[c] !== (c == RSP_CYC + 1)) begin
                tests_failed++;
                $display("[TB] FAIL empty_ready_c%0d: got %b want %b", c, seen_ready[c], c == RSP_CYC + 1);
            end
        end
    endtask

    task automatic test_br_solid();
        rom_mode = 1;
        run_one(11'd40, 11'd40);
        tests_run++;
        if (rsp_count !== 1 || seen_res !== exp_res || seen_res.mask !== 5'b01000 ||
            seen_res.tile !== 4'h3 || seen_blocked !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL br_result: count=%0d mask=%b tile=%h blk=%b want 1 01000 3 1",
                     rsp_count, seen_res.mask, seen_res.tile, seen_blocked);
        end
        tests_run++;
        if (seen_addr[12] !== seen_addr[NPROBE] || bus.rsp_hit_mask !== 5'b01000) begin
            tests_failed++;
            $display("[TB] FAIL br_hold: addr=%h mask=%b want %h 01000",
                     seen_addr[12], bus.rsp_hit_mask, seen_addr[NPROBE]);
        end
    endtask

    task automatic test_oob();
        logic [15:0] exp_addr [4];
        logic [4:0]  exp_mask;
        exp_addr = '{16'h0AFF, 16'h0000, 16'h11FF, 16'h0000};
        exp_mask = (NPROBE == 5) ? 5'b11010 : 5'b01010;
        rom_mode = 3;
        run_one(11'd1020, 11'd40);
        for (int k = 0; k < 4; k++) begin
            tests_run++;
            if (seen_addr[k+1] !== exp_addr[k]) begin
                tests_failed++;
                $display("[TB] FAIL oob_addr%0d: got %h want %h", k, seen_addr[k+1], exp_addr[k]);
            end
        end
        tests_run++;
        if (rsp_count !== 1 || seen_res !== exp_res || seen_res.mask !== exp_mask || seen_res.tile !== 4'hF) begin
            tests_failed++;
            $display("[TB] FAIL oob_result: count=%0d mask=%b tile=%h want 1 %b f",
                     rsp_count, seen_res.mask, seen_res.tile, exp_mask);
        end
    endtask

    task automatic test_back_to_back();
        logic [10:0] xs [5];
        logic [10:0] ys [5];
        int   n_acc, n_rsp, last_acc, since;
        logic exp_rdy, pending;
        res_t e, got;
        xs = '{11'd100, 11'd1020, 11'd0, 11'd600, 11'd2040};
        ys = '{11'd40, 11'd700, 11'd0, 11'd760, 11'd10};
        rom_mode = 3;
        exp_q.delete();
        n_acc    = 0;
        n_rsp    = 0;
        last_acc = -100;
        pending  = 1'b0;
        @(negedge clk);
        bus.req_x     = xs[0];
        bus.req_y     = ys[0];
        bus.req_valid = 1'b1;
        for (int c = 0; c < 80; c++) begin
            since = c - last_acc;
            if (bus.rsp_valid) begin
                n_rsp++;
                tests_run++;
                if (exp_q.size() == 0) begin
                    tests_failed++;
                    $display("[TB] FAIL b2b_extra_rsp: rsp_valid at cycle %0d with 0 pending, want none", c);
                end else begin
                    e   = exp_q.pop_front();
                    got = {bus.rsp_hit_mask, bus.rsp_tile};
                    if (got !== e) begin
                        tests_failed++;
                        $display("[TB] FAIL b2b_result: got mask=%b tile=%h want %b %h", got.mask, got.tile, e.mask, e.tile);
                    end
                end
            end
            exp_rdy = !(since >= 1 && since <= RSP_CYC);
            tests_run++;
            if (bus.req_ready !== exp_rdy) begin
                tests_failed++;
                $display("[TB] FAIL b2b_ready: cycle %0d got %b want %b", c, bus.req_ready, exp_rdy);
            end
            if (bus.req_valid && bus.req_ready) begin
                if (n_acc > 0) begin
                    tests_run++;
                    if (since !== SPACING) begin
                        tests_failed++;
                        $display("[TB] FAIL b2b_spacing: got %0d want %0d", since, SPACING);
                    end
                end
                exp_q.push_back(model(bus.req_x, bus.req_y));
                last_acc = c;
                n_acc++;
                pending = 1'b1;
            end
            @(negedge clk);
            if (pending) begin
                pending = 1'b0;
                if (n_acc < 5) begin
                    bus.req_x = xs[n_acc];
                    bus.req_y = ys[n_acc];
                end else begin
                    bus.req_valid = 1'b0;
                end
            end
        end
        bus.req_valid = 1'b0;
        tests_run++;
        if (n_acc !== 5 || n_rsp !== 5 || exp_q.size() !== 0) begin
            tests_failed++;
            $display("[TB] FAIL b2b_count: accepts=%0d rsps=%0d left=%0d want 5 5 0", n_acc, n_rsp, exp_q.size());
        end
    endtask

    task automatic test_reset_midflight();
        int cnt;
        rom_mode = 1;
        exp_q.delete();
        @(negedge clk);
        bus.req_x     = 11'd40;
        bus.req_y     = 11'd40;
        bus.req_valid = 1'b1;
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        tests_run++;
        if (bus.map_addr !== 16'h110A || bus.req_ready !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL mid_before: addr=%h ready=%b want 110a 0", bus.map_addr, bus.req_ready);
        end
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (bus.req_ready !== 1'b1 || bus.map_addr !== 16'h0000 || bus.rsp_valid !== 1'b0 ||
            bus.rsp_blocked !== 1'b0 || bus.rsp_hit_mask !== 5'd0 || bus.rsp_tile !== 4'd0) begin
            tests_failed++;
            $display("[TB] FAIL mid_reset: ready=%b addr=%h valid=%b blk=%b mask=%b tile=%h want 1 0000 0 0 00000 0",
                     bus.req_ready, bus.map_addr, bus.rsp_valid, bus.rsp_blocked, bus.rsp_hit_mask, bus.rsp_tile);
        end
        @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (bus.rsp_valid) cnt++;
        end
        tests_run++;
        if (cnt !== 0) begin
            tests_failed++;
            $display("[TB] FAIL mid_no_rsp: got %0d strobes want 0", cnt);
        end
        run_one(11'd40, 11'd40);
        tests_run++;
        if (rsp_count !== 1 || rsp_cyc !== RSP_CYC || seen_res !== exp_res || seen_res.tile !== 4'h3) begin
            tests_failed++;
            $display("[TB] FAIL mid_recover: count=%0d cycle=%0d mask=%b tile=%h want 1 %0d %b %h",
                     rsp_count, rsp_cyc, seen_res.mask, seen_res.tile, RSP_CYC, exp_res.mask, exp_res.tile);
        end
    endtask

`ifdef PROBE_CENTER_EN
    task automatic test_center();
        rom_mode = 2;
        run_one(11'd40, 11'd40);
        tests_run++;
        if (seen_addr[5] !== 16'h0E0E) begin
            tests_failed++;
            $display("[TB] FAIL center_addr: got %h want 0e0e", seen_addr[5]);
        end
        tests_run++;
        if (rsp_count !== 1 || rsp_cyc !== 7 || seen_res !== exp_res ||
            seen_res.mask !== 5'b10000 || seen_res.tile !== 4'h5) begin
            tests_failed++;
            $display("[TB] FAIL center_result: count=%0d cycle=%0d mask=%b tile=%h want 1 7 10000 5",
                     rsp_count, rsp_cyc, seen_res.mask, seen_res.tile);
        end
    endtask
`endif

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        test_reset();
        test_empty();
        test_br_solid();
        test_oob();
        test_reset_midflight();
        test_back_to_back();
`ifdef PROBE_CENTER_EN
        test_center();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/map_collision_probe.md
Name: map_collision_probe

Overview:
- Initiator side of the map ROM tile-code read port. Drives the 16-bit tile address and consumes the 4-bit tile code returned by the ROM.
- For each candidate object position it issues one probe per bounding-box corner and collects the returned tile codes. It then reports whether the position is blocked.
- Sits between the player/enemy movement logic and the map ROM tile port, replacing ad-hoc fixed-offset address wiring.

Parameters:
- OBJ_W, 32, object width in screen pixels (>=1)
- OBJ_H, 32, object height in screen pixels (>=1)
- SCALE_SH, 2, right-shift from screen pixel to map cell coordinate
- MAP_W, 256, map width in cells (<=256; ROM row stride fixed at 256)
- MAP_H, 192, map height in cells (<=256)
- SOLID_MIN, 4'h1, tile codes >= SOLID_MIN are solid
- ROM_LAT, 1, ROM read latency in clocks (registered output = 1)

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  1  probe request
- req_ready  output  1  block idle, request accepted when req_valid&&req_ready
- req_x  input  11  candidate top-left x, screen pixels
- req_y  input  11  candidate top-left y, screen pixels
- map_addr  output  16  tile address to ROM, {cell_y[7:0], cell_x[7:0]}
- map_data  input  4  tile code from ROM, ROM_LAT cycles after map_addr
- rsp_valid  output  1  one-cycle result strobe
- rsp_blocked  output  1  any probed point solid or out of bounds
- rsp_hit_mask  output  5  per-probe blocked flags; bit0 TL, bit1 TR, bit2 BL, bit3 BR, bit4 centre
- rsp_tile  output  4  code of the lowest-index blocked probe; 0 if none

Behaviour:
- Reset (async, rst_n=0): state IDLE, req_ready=1, map_addr=0, rsp_valid=0, rsp_blocked=0, rsp_hit_mask=0, rsp_tile=0. In-flight probes are discarded, and no rsp_valid is issued for them.
- States:
  - IDLE: req_ready=1. On accept, latch req_x/req_y and go to ISSUE.
  - ISSUE: one probe address per cycle. After the last probe, go to DRAIN.
  - DRAIN: wait for the remaining ROM data.
  - DONE: rsp_valid=1 for one cycle, then IDLE.
- Probe points (12-bit arithmetic, no overflow):
  - TL = (x, y)
  - TR = (x+OBJ_W-1, y)
  - BL = (x, y+OBJ_H-1)
  - BR = (x+OBJ_W-1, y+OBJ_H-1)
  - Cell coordinates = point >> SCALE_SH.
- Out of bounds: a probe is out of bounds if cell_x >= MAP_W or cell_y >= MAP_H.
  - Its address is still issued, forced to 16'h0000, so pipeline timing is unchanged.
  - Its flag is forced to 1 and its code is taken as 4'hF, ignoring map_data.
- Timing: with acceptance in cycle 0, probe k (k=0..NPROBE-1) is on map_addr in cycle k+1. Its map_data is sampled at the end of cycle k+1+ROM_LAT.
- Result timing: rsp_valid is high in cycle NPROBE+ROM_LAT+1. NPROBE=4, so this is cycle 6 for ROM_LAT=1. req_ready returns high in the following cycle.
- Classification: a probe is blocked if its code >= SOLID_MIN (unsigned) or it is out of bounds.
  - rsp_blocked = OR of rsp_hit_mask.
  - rsp_hit_mask[4] = 0 when the centre probe is disabled.
- Holding: map_addr holds its last value outside ISSUE. rsp_* hold their values until the next DONE.
- req_ready=0 from acceptance through DONE. req_valid in that window is ignored and not queued.
- Back-to-back requests: one request per NPROBE+ROM_LAT+2 cycles maximum.

Optional Feature:
- Macro: PROBE_CENTER_EN.
- Defined: NPROBE=5. Fifth probe C = (x+OBJ_W/2, y+OBJ_H/2), issued after BR, with its result in rsp_hit_mask[4]. Result latency grows by 1 cycle.
- Not defined: NPROBE=4, rsp_hit_mask[4] tied to 0, no centre logic.

Test Plan:
- Empty map region (map_data always 0), req (40,40) -> map_addr sequence 0x0A0A, 0x0A11, 0x110A, 0x1111 in cycles 1-4. rsp_valid in cycle 6 only, blocked=0, mask=0, tile=0.
- Model returns code 3 only at address 0x1111 (BR), req (40,40) -> blocked=1, mask=5'b01000, tile=3.
- req (1020,40) with MAP_W=256 -> TR/BR out of bounds: mask=5'b01010, tile=4'hF, map_addr=0x0000 in cycles 2 and 4.
- req_valid held high continuously -> accepts spaced 7 cycles apart; req_ready=0 during busy; no lost or duplicate rsp_valid.
- rst_n dropped in cycle 3 of a probe -> outputs reset immediately, no rsp_valid after release; a new request completes normally.
- PROBE_CENTER_EN, code 5 only at centre cell, req (40,40) -> 5th address 0x0E0E, mask=5'b10000, tile=5, rsp_valid in cycle 7.
